// File: rtl/hps_status_pkg.sv
// Shared definitions for the HPS status reader: register map, STATUS bit layout, period FSM states.
package hps_status_pkg;

    localparam int ADDR_STATUS      = 0;
    localparam int ADDR_TURN_PERIOD = 1;
    localparam int ADDR_TURN_COUNT  = 2;
    localparam int ADDR_FRAME_COUNT = 3;

    localparam int ST_TURN_SEEN  = 0;
    localparam int ST_FRAME_SEEN = 1;
    localparam int ST_OVERFLOW   = 2;
    localparam int ST_STALLED    = 3;
    localparam int ST_MEASURING  = 4;

    typedef enum logic {IDLE, MEASURE} period_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge pulse generator for sensor inputs.
// Define HPS_STATUS_SYNC_EN to add a 2-FF synchroniser ahead of the edge detect.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_in_n,
    input  logic din,
    output logic pulse
);

    logic lvl;
    logic prev_q;

`ifdef HPS_STATUS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_in_n) sync_q <= '0;
        else           sync_q <= {sync_q[0], din};
    end

    assign lvl = sync_q[1];
`else
    assign lvl = din;
`endif

    always_ff @(posedge clk) begin
        if (!rst_in_n) prev_q <= 1'b0;
        else           prev_q <= lvl;
    end

    assign pulse = lvl & ~prev_q;

endmodule

// File: rtl/hps_status_reader.sv
// HPS-readable status slave: turn-period measurement, turn/frame counters, sticky flags.
// Read latency 1; turn_tick synchroniser selected by HPS_STATUS_SYNC_EN (see sync_edge_detect).
module hps_status_reader
    import hps_status_pkg::*;
#(
    parameter int R_ADDR_WIDTH = 2,
    parameter int R_DATA_WIDTH = 32,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_in_n,
    input  logic [R_ADDR_WIDTH-1:0] r_addr,
    input  logic                    read,
    output logic [R_DATA_WIDTH-1:0] r_data,
    output logic                    r_valid,
    input  logic                    turn_tick,
    input  logic                    frame_done,
    input  logic                    fifo_overflow
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

    period_state_t           state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    stalled_q, stalled_d;
    logic                    tick_edge;
    logic                    turn_seen_q, frame_seen_q, overflow_q;
    logic [R_DATA_WIDTH-1:0] turn_cnt_q, frame_cnt_q;
    logic [R_DATA_WIDTH-1:0] rd_mux;
    logic                    clr_flags;
    logic [0:0]              vld_pipe;

    sync_edge_detect u_tick_edge (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .din      (turn_tick),
        .pulse    (tick_edge)
    );

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            stalled_q <= stalled_d;
        end
    end

    // A tick edge takes priority over saturation so a period of exactly all-ones still measures.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        stalled_d = stalled_q;
        if (tick_edge) stalled_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tick_edge) begin
                    state_d = MEASURE;
                    cnt_d   = PERIOD_WIDTH'(1);
                end
            end
            MEASURE: begin
                if (tick_edge) begin
                    period_d = cnt_q;
                    cnt_d    = PERIOD_WIDTH'(1);
                end else if (cnt_q == CNT_MAX) begin
                    period_d  = CNT_MAX;
                    stalled_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_WIDTH'(1);
                end
            end
        endcase
    end

    assign clr_flags = read && (r_addr == R_ADDR_WIDTH'(ADDR_STATUS));

    // New events override the clear so an event coinciding with a STATUS read is not lost.
    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            turn_seen_q  <= 1'b0;
            frame_seen_q <= 1'b0;
            overflow_q   <= 1'b0;
            turn_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            turn_seen_q  <= tick_edge     | (turn_seen_q  & ~clr_flags);
            frame_seen_q <= frame_done    | (frame_seen_q & ~clr_flags);
            overflow_q   <= fifo_overflow | (overflow_q   & ~clr_flags);
            if (tick_edge)  turn_cnt_q  <= turn_cnt_q  + R_DATA_WIDTH'(1);
            if (frame_done) frame_cnt_q <= frame_cnt_q + R_DATA_WIDTH'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (r_addr)
            R_ADDR_WIDTH'(ADDR_STATUS): begin
                rd_mux[ST_TURN_SEEN]  = turn_seen_q;
                rd_mux[ST_FRAME_SEEN] = frame_seen_q;
                rd_mux[ST_OVERFLOW]   = overflow_q;
                rd_mux[ST_STALLED]    = stalled_q;
                rd_mux[ST_MEASURING]  = (state_q == MEASURE);
            end
            R_ADDR_WIDTH'(ADDR_TURN_PERIOD): rd_mux[PERIOD_WIDTH-1:0] = period_q;
            R_ADDR_WIDTH'(ADDR_TURN_COUNT):  rd_mux = turn_cnt_q;
            R_ADDR_WIDTH'(ADDR_FRAME_COUNT): rd_mux = frame_cnt_q;
            default:                         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            vld_pipe <= '0;
            r_data   <= '0;
        end else begin
            vld_pipe <= read;
            if (read) r_data <= rd_mux;
        end
    end

    assign r_valid = vld_pipe[0];

endmodule
